// File: rtl/systolic_feeder.sv
// systolic_feeder: loads a weight tile into a weight-stationary systolic array, then streams skewed activations.
// Optional feature macro SYSTOLIC_FEEDER_REUSE_EN adds i_reuse_w to skip weight loading and reuse the latched tile.
module systolic_feeder #(
    parameter int ROWS          = 4,
    parameter int COLS          = 4,
    parameter int IN_DATA_WIDTH = 8,
    parameter int CNT_WIDTH     = 16
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          i_start,
    input  logic [CNT_WIDTH-1:0]          i_num_vec,
`ifdef SYSTOLIC_FEEDER_REUSE_EN
    input  logic                          i_reuse_w,
`endif
    input  logic                          i_w_valid,
    output logic                          o_w_ready,
    input  logic [COLS*IN_DATA_WIDTH-1:0] i_w_data,
    input  logic                          i_a_valid,
    output logic                          o_a_ready,
    input  logic [ROWS*IN_DATA_WIDTH-1:0] i_a_data,
    output logic                          o_weight_en,
    output logic [COLS*IN_DATA_WIDTH-1:0] o_north_weight,
    output logic [ROWS*IN_DATA_WIDTH-1:0] o_west_act,
    output logic [COLS-1:0]               o_psum_valid,
    output logic                          o_busy,
    output logic                          o_done
);
    localparam int IW = IN_DATA_WIDTH;
    localparam int RW = ROWS > 1 ? $clog2(ROWS) : 1;
    localparam int CW = $clog2(ROWS + COLS);
    localparam logic [CW-1:0] W_LAST = CW'(ROWS - 1);
    localparam logic [CW-1:0] D_LAST = CW'(ROWS + COLS - 1);

    typedef enum logic [2:0] {IDLE, LOAD_W, PUSH_W, STREAM, DRAIN} state_t;

    state_t                r_state, w_state_nxt;
    logic [CW-1:0]         r_cnt;
    logic [CNT_WIDTH-1:0]  r_left;
    logic [COLS*IW-1:0]    r_buf [ROWS];
    logic [COLS*IW-1:0]    r_north;
    logic [ROWS-1:0]       r_acc_sr;
    logic [COLS-1:0]       r_psum;
    logic                  r_w_ready, r_a_ready, r_weight_en, r_busy, r_done;
    logic                  w_w_acc, w_a_acc, w_reuse, w_inc;
    logic [RW-1:0]         w_idx;
    logic [COLS*IW-1:0]    w_north_nxt;

    assign w_w_acc = i_w_valid & r_w_ready;
    assign w_a_acc = i_a_valid & r_a_ready;
`ifdef SYSTOLIC_FEEDER_REUSE_EN
    assign w_reuse = i_reuse_w;
`else
    assign w_reuse = 1'b0;
`endif

    always_ff @(posedge clk or negedge rstn)
        if (!rstn) r_state <= IDLE;
        else       r_state <= w_state_nxt;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (i_start) w_state_nxt = !w_reuse ? LOAD_W : (i_num_vec == '0 ? DRAIN : STREAM);
            LOAD_W:  if (w_w_acc && r_cnt == W_LAST) w_state_nxt = PUSH_W;
            PUSH_W:  if (r_cnt == W_LAST) w_state_nxt = r_left == '0 ? IDLE : STREAM;
            STREAM:  if (w_a_acc && r_left == CNT_WIDTH'(1)) w_state_nxt = DRAIN;
            DRAIN:   if (r_cnt == D_LAST) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Outputs are computed one cycle early and registered, so the push burst has no gaps.
    always_comb begin
        w_inc       = r_state == LOAD_W ? w_w_acc : (r_state == PUSH_W || r_state == DRAIN);
        w_idx       = r_state == PUSH_W ? RW'(r_cnt + CW'(1)) : '0;
        w_north_nxt = w_state_nxt != PUSH_W ? '0 : (r_state == LOAD_W && ROWS == 1) ? i_w_data : r_buf[w_idx];
    end

    always_ff @(posedge clk or negedge rstn)
        if (!rstn) begin
            r_cnt       <= '0;
            r_left      <= '0;
            r_w_ready   <= 1'b0;
            r_a_ready   <= 1'b0;
            r_weight_en <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_north     <= '0;
            r_acc_sr    <= '0;
            r_psum      <= '0;
            for (int k = 0; k < ROWS; k++) r_buf[k] <= '0;
        end else begin
            r_cnt       <= w_state_nxt != r_state ? '0 : r_cnt + CW'(w_inc);
            r_left      <= (r_state == IDLE && i_start) ? i_num_vec : r_left - CNT_WIDTH'(w_a_acc);
            if (w_w_acc) r_buf[RW'(r_cnt)] <= i_w_data;
            r_w_ready   <= w_state_nxt == LOAD_W;
            r_a_ready   <= w_state_nxt == STREAM;
            r_weight_en <= w_state_nxt == PUSH_W;
            r_busy      <= w_state_nxt != IDLE;
            r_done      <= r_state != IDLE && w_state_nxt == IDLE;
            r_north     <= w_north_nxt;
            r_acc_sr    <= ROWS'({r_acc_sr, w_a_acc});
            r_psum      <= COLS'({r_psum, r_acc_sr[ROWS-1]});
        end

    // Lane r passes through r+1 registers, giving the diagonal skew.
    for (genvar r = 0; r < ROWS; r++) begin : g_lane
        logic [IW-1:0] r_chain [r+1];
        always_ff @(posedge clk or negedge rstn)
            if (!rstn) begin
                for (int k = 0; k <= r; k++) r_chain[k] <= '0;
            end else begin
                r_chain[0] <= w_a_acc ? i_a_data[r*IW +: IW] : '0;
                for (int k = 1; k <= r; k++) r_chain[k] <= r_chain[k-1];
            end
        assign o_west_act[r*IW +: IW] = r_chain[r];
    end

    assign o_w_ready      = r_w_ready;
    assign o_a_ready      = r_a_ready;
    assign o_weight_en    = r_weight_en;
    assign o_north_weight = r_north;
    assign o_psum_valid   = r_psum;
    assign o_busy         = r_busy;
    assign o_done         = r_done;
endmodule

// File: tb/tb_systolic_feeder.sv
// tb_systolic_feeder: scoreboard bench; stimulus queues expected beats with due cycles, a monitor checks every cycle.
module tb_systolic_feeder;
    localparam int R = 4, C = 4, IW = 8;

    logic clk = 0, rstn = 0, i_start = 0, i_w_valid = 0, i_a_valid = 0, reuse_w = 0;
    logic [15:0] i_num_vec = '0;
    logic [C*IW-1:0] i_w_data = '0;
    logic [R*IW-1:0] i_a_data = '0;
    logic o_w_ready, o_a_ready, o_weight_en, o_busy, o_done;
    logic [C*IW-1:0] o_north_weight;
    logic [R*IW-1:0] o_west_act;
    logic [C-1:0] o_psum_valid;

    systolic_feeder dut (
        .clk(clk), .rstn(rstn), .i_start(i_start), .i_num_vec(i_num_vec),
`ifdef SYSTOLIC_FEEDER_REUSE_EN
        .i_reuse_w(reuse_w),
`endif
        .i_w_valid(i_w_valid), .o_w_ready(o_w_ready), .i_w_data(i_w_data),
        .i_a_valid(i_a_valid), .o_a_ready(o_a_ready), .i_a_data(i_a_data),
        .o_weight_en(o_weight_en), .o_north_weight(o_north_weight), .o_west_act(o_west_act),
        .o_psum_valid(o_psum_valid), .o_busy(o_busy), .o_done(o_done)
    );

    always #5 clk = ~clk;

    int cyc = 0, n_tests = 0, n_fail = 0, n_aready = 0;
    bit mon_en = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int t; logic [R*IW-1:0] v; } aent_t;
    typedef struct { int t; logic [C*IW-1:0] v; } went_t;
    aent_t aq[$];
    went_t wq[$];
    int    dq[$];
    logic [C*IW-1:0] wrow [R];
    logic [R*IW-1:0] vecs [8];

    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] pk(input int a, input int b, input int c, input int d);
        return {d[7:0], c[7:0], b[7:0], a[7:0]};
    endfunction

    logic [R*IW-1:0] m_west;
    logic [C-1:0]    m_psum;
    logic            m_we, m_done;
    always @(negedge clk) if (mon_en && rstn) begin
        m_west = '0;
        m_psum = '0;
        foreach (aq[i]) begin
            for (int r = 0; r < R; r++) if (aq[i].t + r == cyc) m_west[r*IW +: IW] = aq[i].v[r*IW +: IW];
            for (int c = 0; c < C; c++) if (aq[i].t + R + c == cyc) m_psum[c] = 1'b1;
        end
        check("west_act", o_west_act, m_west);
        check("psum_valid", o_psum_valid, m_psum);
        m_we = wq.size() > 0 && wq[0].t == cyc;
        check("weight_en", o_weight_en, m_we);
        if (m_we) begin
            check("north_weight", o_north_weight, wq[0].v);
            void'(wq.pop_front());
        end
        m_done = dq.size() > 0 && dq[0] == cyc;
        check("done", o_done, m_done);
        if (m_done) begin
            check("busy_at_done", o_busy, 0);
            void'(dq.pop_front());
        end
        while (aq.size() > 0 && aq[0].t + R + C < cyc) void'(aq.pop_front());
        if (o_a_ready) n_aready++;
    end

    task automatic start_job(input int n);
        i_start = 1; i_num_vec = 16'(n);
        @(posedge clk); #1 i_start = 0;
        @(negedge clk);
        check("w_ready_after_start", {o_w_ready, o_busy}, 2'b11);
        @(posedge clk); #1;
    endtask

    task automatic send_weights(input bit zero_vec);
        int t, last;
        for (int k = 0; k < R; k++) begin
            i_w_valid = 1; i_w_data = wrow[k]; t = -1;
            for (int i = 0; i < 40 && t < 0; i++) begin
                @(negedge clk);
                if (o_w_ready) t = cyc + 1;
            end
            if (t < 0) check("timeout_w_ready", 0, 1);
            last = t;
            @(posedge clk); #1 i_w_valid = 0;
        end
        for (int k = 0; k < R; k++) wq.push_back('{last + k, wrow[k]});
        if (zero_vec) dq.push_back(last + R);
    endtask

    task automatic beat_a(input logic [R*IW-1:0] d, output int t);
        i_a_valid = 1; i_a_data = d; t = -1;
        for (int i = 0; i < 40 && t < 0; i++) begin
            @(negedge clk);
            if (o_a_ready) t = cyc + 1;
        end
        if (t < 0) check("timeout_a_ready", 0, 1);
        @(posedge clk); #1 i_a_valid = 0;
        aq.push_back('{t, d});
    endtask

    task automatic send_vecs(input int n, input bit gaps, input bit poke_start);
        int t;
        for (int i = 0; i < n; i++) begin
            if (gaps && i % 2 == 1) begin
                i_a_valid = 0;
                @(posedge clk); #1;
            end
            if (poke_start && i == 1) begin i_start = 1; i_num_vec = 16'd99; end
            beat_a(vecs[i], t);
            i_start = 0;
            if (i == n - 1) dq.push_back(t + R + C);
        end
    endtask

    task automatic wait_done();
        bit seen = 0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clk);
            seen = o_done;
        end
        if (!seen) check("timeout_done", 0, 1);
        @(posedge clk); #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_ctrl", {o_w_ready, o_a_ready, o_weight_en, o_busy, o_done, o_psum_valid}, '0);
        check("reset_data", {o_north_weight, o_west_act}, '0);
        @(posedge clk); #1 rstn = 1; mon_en = 1;
        @(posedge clk); #1;

        // rows 0..3 = {1..4},{5..8},{9..12},{13..16}, bottom row first
        wrow[0] = pk(13, 14, 15, 16); wrow[1] = pk(9, 10, 11, 12);
        wrow[2] = pk(5, 6, 7, 8);     wrow[3] = pk(1, 2, 3, 4);
        start_job(1);
        send_weights(0);
        vecs[0] = pk(1, 2, 3, 4);
        send_vecs(1, 0, 0);
        wait_done();

        // identity tile, back-to-back start right after done
        for (int k = 0; k < R; k++) wrow[k] = 32'(1) << ((R - 1 - k) * IW);
        start_job(3);
        send_weights(0);
        vecs[0] = pk(1, 2, 3, 4); vecs[1] = pk(5, 6, 7, 8); vecs[2] = pk(-1, -2, -3, -4);
        send_vecs(3, 0, 0);
        wait_done();

        // a_valid gaps, and a start pulse while busy that must be ignored
        start_job(4);
        send_weights(0);
        vecs[0] = pk(10, 20, 30, 40); vecs[1] = pk(-128, 127, 0, -1);
        vecs[2] = pk(7, 7, 7, 7);     vecs[3] = pk(1, 0, 0, 0);
        send_vecs(4, 1, 1);
        wait_done();

        // num_vec = 0: done straight after the push, no a_ready
        n_aready = 0;
        start_job(0);
        send_weights(1);
        wait_done();
        check("no_a_ready_zero_job", n_aready, 0);

        // reset mid-stream aborts without done
        start_job(3);
        send_weights(0);
        vecs[0] = pk(3, 5, 7, 9);
        send_vecs(1, 0, 0);
        dq.delete();
        repeat (2) @(negedge clk);
        rstn = 0; aq.delete(); wq.delete(); dq.delete();
        @(negedge clk);
        check("abort_ctrl", {o_w_ready, o_a_ready, o_weight_en, o_busy, o_done, o_psum_valid}, '0);
        check("abort_data", {o_north_weight, o_west_act}, '0);
        @(posedge clk); #1 rstn = 1;
        repeat (10) @(posedge clk);
        #1 check("idle_after_abort", {o_busy, o_done}, 2'b00);

        wrow[0] = pk(-5, 6, -7, 8); wrow[1] = pk(0, 0, 0, 1);
        wrow[2] = pk(127, -128, 1, -1); wrow[3] = pk(2, 4, 6, 8);
        start_job(2);
        send_weights(0);
        vecs[0] = pk(-1, 0, 1, 2); vecs[1] = pk(100, -100, 50, -50);
        send_vecs(2, 0, 0);
        wait_done();

        repeat (10) @(posedge clk);
        #1;
        check("weights_pending", wq.size(), 0);
        check("done_pending", dq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/systolic_feeder.md
# systolic_feeder

Front-end driver for the weight-stationary systolic array of PEs. It collects one weight tile over a valid/ready stream and pushes it down the array's north edge in a single gap-free burst under `weight_en`. It then streams activation vectors into the west edge with the per-row diagonal skew the array requires. It also flags, per column, the cycle in which a valid partial sum leaves the bottom row.

## Interface
- `ROWS`, 4, array rows (activation lanes)
- `COLS`, 4, array columns (weight lanes / psum outputs)
- `IN_DATA_WIDTH`, 8, signed weight/activation width
- `CNT_WIDTH`, 16, width of vector count
- `clk`  in  1  clock
- `rstn`  in  1  reset, asynchronous, active-low
- `start`  in  1  begin a job; sampled only in IDLE
- `num_vec`  in  CNT_WIDTH  activation vectors in job; sampled with `start`
- `w_valid` / `w_ready`  in / out  1  weight-row handshake
- `w_data`  in  COLS*IN_DATA_WIDTH  one weight row; lane c = bits [c*IW +: IW]
- `a_valid` / `a_ready`  in / out  1  activation-vector handshake
- `a_data`  in  ROWS*IN_DATA_WIDTH  one vector; lane r feeds array row r
- `weight_en`  out  1  broadcast to all PEs
- `north_weight`  out  COLS*IN_DATA_WIDTH  to top-row `in_north_weight`
- `west_act`  out  ROWS*IN_DATA_WIDTH  to column-0 `in_west`, skewed
- `psum_valid`  out  COLS  bottom-row `out_south_psum[c]` holds a result
- `busy`  out  1  state != IDLE
- `done`  out  1  one-cycle job-complete pulse

## Operation
- States: IDLE -> LOAD_W -> PUSH_W -> STREAM -> DRAIN -> IDLE.
- IDLE: all handshakes low. `start`=1 latches `num_vec` and moves to LOAD_W.
- LOAD_W: `w_ready`=1. Beat k (k=0..ROWS-1) is stored in buffer entry k. Beat k is the weights for array row ROWS-1-k, so the bottom row is sent first. After ROWS beats, `w_ready` drops and the state moves to PUSH_W.
- PUSH_W: exactly ROWS consecutive cycles with `weight_en`=1. `north_weight` = entry k in push cycle k. `west_act` = 0. No gaps are allowed, because the PE weight pipeline shifts every cycle.
  - If `num_vec`=0: go to IDLE and pulse `done`.
  - Otherwise: go to STREAM.
- STREAM: `a_ready`=1 until `num_vec` beats are accepted. `a_valid` gaps are allowed; an idle cycle injects zeros. After the last accept, the state moves to DRAIN.
- Skew: lane r of `west_act` is the accepted lane-r value delayed r extra cycles through a per-lane register chain. Lane 0 has no extra delay.
- DRAIN: `a_ready`=0 and zeros are fed. After ROWS+COLS cycles the block goes to IDLE with `done`=1 on that transition.
- `weight_en` is never asserted while any activation is in flight.
- `psum_valid` is a COLS-stage shift chain seeded by the accept strobe delayed ROWS cycles. Bit c = bit c-1 delayed one cycle.
- `start` outside IDLE is ignored.
- The feeder does no arithmetic; values pass through bit-exact.

## Timing
- Reset values: state IDLE; `w_ready`, `a_ready`, `weight_en`, `busy`, `done` = 0; `north_weight`, `west_act`, `psum_valid` = 0; skew chains and buffer cleared.
- Reset mid-job aborts immediately. There is no `done` pulse; the next job requires `start`.
- All outputs are registered.
- `start` at edge T: `w_ready`=1 from cycle T+1.
- Last weight accepted at edge T: `weight_en`=1 during cycles T+1..T+ROWS.
- Vector accepted at edge t:
  - `west_act` lane r carries it in cycle t+1+r.
  - `psum_valid[c]`=1 in cycle t+1+ROWS+c.
- Last vector accepted at edge t: `done`=1 in cycle t+ROWS+COLS+1; `busy` falls in the same cycle.
- Back-to-back: a `start` in the cycle after `done` is accepted.

## Configuration
- `SYSTOLIC_FEEDER_REUSE_EN` defined: adds input `reuse_w` (1 bit), sampled with `start`. If `reuse_w`=1, LOAD_W and PUSH_W are skipped and the job goes straight to STREAM using the weights already latched in the array.
- Not defined: the port is absent and every job loads weights.

## Test plan
- ROWS=COLS=4, rows {1..4},{5..8},{9..12},{13..16} sent bottom-first -> `weight_en` high exactly 4 contiguous cycles; a golden PE array ends holding row r = its row.
- Identity weights, num_vec=3, vectors {1,2,3,4},{5,6,7,8},{-1,-2,-3,-4} -> bottom psums equal the inputs, flagged by `psum_valid` at t+5+c.
- `a_valid` toggled 1,0,1,0 -> zeros inserted, `psum_valid` marks only real beats, results unchanged.
- num_vec=0 -> `done` one cycle after the last `weight_en`, no `a_ready`.
- `rstn` pulsed low mid-STREAM -> all outputs 0 next cycle, no `done`; a new job runs correctly.
- With REUSE_EN: second job `reuse_w`=1 -> `weight_en` never rises, results match the first tile.
